pinball_game_ctrl: RTL

- Game-flow sequencer for the pinball ball datapath.
- Owns the ball's reset, motion enable and per-axis move strobes, replacing free-running move counters inside the ball block.
- Tracks lives and accumulates score from one-cycle obstacle hit pulses produced by collision logic.
- Sits between the button/input debouncers, the ball block and the score/status display.

---
 rtl/pinball_game_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pinball_game_ctrl.sv
// Pinball game-flow sequencer.
// Drives the ball block's reset, motion enable and per-axis move strobes,
// keeps the remaining lives and accumulates the score from obstacle hits.
// All outputs come straight from flops, so a condition sampled at one edge
// is visible on the outputs after the following edge.
module pinball_game_ctrl #(
    parameter int LIVES       = 3,
    parameter int DRAIN_Y     = 470,
    parameter int SPEED_Y     = 240,
    parameter int TICK_PERIOD = 250000,
    parameter int DRAIN_WAIT  = 25000000,
    parameter int RED_PTS     = 10,
    parameter int GREEN_PTS   = 20,
    parameter int PURPLE_PTS  = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        launch,
    input  logic [11:0] ball_y,
    input  logic        hit_red,
    input  logic        hit_green,
    input  logic        hit_purple,
    output logic        ball_rst,
    output logic        move_en,
    output logic        x_tick,
    output logic        y_tick,
    output logic [2:0]  state,
    output logic [1:0]  lives,
    output logic [15:0] score
);

    localparam int TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int DW = (DRAIN_WAIT > 1) ? $clog2(DRAIN_WAIT) : 1;

    localparam logic [TW-1:0] X_LAST      = TW'(TICK_PERIOD - 1);
    localparam logic [TW-1:0] Y_FAST_LAST = TW'((TICK_PERIOD / 2) - 1);
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_WAIT - 1);
    localparam logic [11:0]   DRAIN_Y_C   = 12'(DRAIN_Y);
    localparam logic [11:0]   SPEED_Y_C   = 12'(SPEED_Y);
    localparam logic [1:0]    LIVES_C     = 2'(LIVES);
    localparam logic [16:0]   RED_C       = 17'(RED_PTS);
    localparam logic [16:0]   GREEN_C     = 17'(GREEN_PTS);
    localparam logic [16:0]   PURPLE_C    = 17'(PURPLE_PTS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_DRAIN = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t         state_r;
    logic [1:0]     lives_r;
    logic [15:0]    score_r;
    logic           ball_rst_r;
    logic           move_en_r;
    logic           x_tick_r;
    logic           y_tick_r;
    logic [TW-1:0]  x_cnt_r;
    logic [TW-1:0]  y_cnt_r;
    logic [DW-1:0]  drain_cnt_r;

    logic [TW-1:0]  y_last_s;
    logic           drain_hit_s;
    logic [16:0]    hit_pts_s;
    logic [16:0]    score_sum_s;
    logic [15:0]    score_next_s;

    // Per-cycle decode: y strobe wrap limit, drain detect and saturating score sum.
    always_comb begin
        y_last_s     = X_LAST;
        drain_hit_s  = 1'b0;
        hit_pts_s    = 17'd0;
        score_sum_s  = 17'd0;
        score_next_s = score_r;
        if (ball_y > SPEED_Y_C) begin
            y_last_s = Y_FAST_LAST;
        end else begin
            y_last_s = X_LAST;
        end
        drain_hit_s = (ball_y >= DRAIN_Y_C);
        hit_pts_s   = (hit_red    ? RED_C    : 17'd0)
                    + (hit_green  ? GREEN_C  : 17'd0)
                    + (hit_purple ? PURPLE_C : 17'd0);
        score_sum_s = {1'b0, score_r} + hit_pts_s;
        if (score_sum_s[16]) begin
            score_next_s = 16'hFFFF;
        end else begin
            score_next_s = score_sum_s[15:0];
        end
    end

    // Game FSM with registered ball controls, move strobes, lives and score.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            lives_r     <= LIVES_C;
            score_r     <= 16'd0;
            ball_rst_r  <= 1'b1;
            move_en_r   <= 1'b0;
            x_tick_r    <= 1'b0;
            y_tick_r    <= 1'b0;
            x_cnt_r     <= '0;
            y_cnt_r     <= '0;
            drain_cnt_r <= '0;
        end else begin
            // Strobes are single-cycle and counters rest at zero outside PLAY.
            x_tick_r <= 1'b0;
            y_tick_r <= 1'b0;
            x_cnt_r  <= '0;
            y_cnt_r  <= '0;
            case (state_r)
                S_IDLE, S_OVER: begin
                    ball_rst_r  <= 1'b1;
                    move_en_r   <= 1'b0;
                    drain_cnt_r <= '0;
                    if (start) begin
                        state_r <= S_READY;
                        lives_r <= LIVES_C;
                        score_r <= 16'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_READY: begin
                    drain_cnt_r <= '0;
                    if (launch) begin
                        state_r    <= S_PLAY;
                        ball_rst_r <= 1'b0;
                        move_en_r  <= 1'b1;
                    end else begin
                        ball_rst_r <= 1'b1;
                        move_en_r  <= 1'b0;
                    end
                end
                S_PLAY: begin
                    // Hits landing on the drain cycle still score.
                    score_r    <= score_next_s;
                    ball_rst_r <= 1'b0;
                    if (drain_hit_s) begin
                        state_r     <= S_DRAIN;
                        move_en_r   <= 1'b0;
                        drain_cnt_r <= '0;
                        if (lives_r != 2'd0) begin
                            lives_r <= lives_r - 2'd1;
                        end else begin
                            lives_r <= 2'd0;
                        end
                    end else begin
                        move_en_r <= 1'b1;
                        if (x_cnt_r == X_LAST) begin
                            x_tick_r <= 1'b1;
                        end else begin
                            x_cnt_r <= x_cnt_r + TW'(1);
                        end
                        // >= lets a freshly lowered limit wrap at once.
                        if (y_cnt_r >= y_last_s) begin
                            y_tick_r <= 1'b1;
                        end else begin
                            y_cnt_r <= y_cnt_r + TW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    move_en_r <= 1'b0;
                    if (drain_cnt_r == DRAIN_LAST) begin
                        drain_cnt_r <= '0;
                        ball_rst_r  <= 1'b1;
                        if (lives_r == 2'd0) begin
                            state_r <= S_OVER;
                        end else begin
                            state_r <= S_READY;
                        end
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DW'(1);
                        ball_rst_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    ball_rst_r  <= 1'b1;
                    move_en_r   <= 1'b0;
                    drain_cnt_r <= '0;
                end
            endcase
        end
    end

    assign state    = state_r;
    assign lives    = lives_r;
    assign score    = score_r;
    assign ball_rst = ball_rst_r;
    assign move_en  = move_en_r;
    assign x_tick   = x_tick_r;
    assign y_tick   = y_tick_r;

endmodule
